// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider: divided square wave, one-cycle period tick,
// and a divisor that is only swapped in at a period boundary or on Restart.
module clock_divider_prog #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 50000
) (
  input  logic             ClockIn,
  input  logic             ResetN,
  input  logic             Enable,
  input  logic             Restart,
  input  logic [WIDTH-1:0] DivIn,
  input  logic             DivLoad,
  output logic             ClockOut,
  output logic             TickOut,
  output logic             DivBusy,
  output logic [WIDTH-1:0] CountOut
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_active;
  logic [WIDTH-1:0] r_pending;
  logic             r_busy;
  logic             r_clk;
  logic             r_tick;

  logic [WIDTH-1:0] w_div_clamped;
  logic [WIDTH-1:0] w_deff;
  logic             w_wrap;
  logic             w_swap;
  logic [WIDTH-1:0] w_next_active;
  logic [WIDTH-1:0] w_next_count;
  logic [WIDTH-1:0] w_next_deff;
  logic [WIDTH-1:0] w_next_high_at;
  logic             w_next_clk;

  assign w_div_clamped = (DivIn < MIN_DIV) ? MIN_DIV : DivIn;
  assign w_deff        = (r_active < MIN_DIV) ? MIN_DIV : r_active;
  assign w_wrap        = Enable && !Restart && (r_count == w_deff - ONE);
  assign w_swap        = Restart || w_wrap;

  // A strobe coinciding with the boundary bypasses Pending so it lands immediately.
  always_comb begin
    w_next_active = r_active;
    if (w_swap) begin
      if (DivLoad)
        w_next_active = w_div_clamped;
      else if (Restart || r_busy)
        w_next_active = r_pending;
    end
  end

  always_comb begin
    w_next_count = r_count;
    if (Restart || w_wrap)
      w_next_count = '0;
    else if (Enable)
      w_next_count = r_count + ONE;
  end

  // ClockOut is derived from the post-edge count and divisor so it stays aligned with CountOut.
  assign w_next_deff    = (w_next_active < MIN_DIV) ? MIN_DIV : w_next_active;
  assign w_next_high_at = w_next_deff - (w_next_deff >> 1);
  assign w_next_clk     = (w_next_count >= w_next_high_at);

  always_ff @(posedge ClockIn or negedge ResetN) begin
    if (!ResetN) begin
      r_count   <= '0;
      r_active  <= DEF_DIV;
      r_pending <= DEF_DIV;
      r_busy    <= 1'b0;
      r_clk     <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_count  <= w_next_count;
      r_active <= w_next_active;
      r_clk    <= w_next_clk;
      r_tick   <= w_wrap;
      if (DivLoad)
        r_pending <= w_div_clamped;
      if (w_swap)
        r_busy <= 1'b0;
      else if (DivLoad)
        r_busy <= 1'b1;
    end
  end

  assign ClockOut = r_clk;
  assign TickOut  = r_tick;
  assign DivBusy  = r_busy;
  assign CountOut = r_count;

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
Runtime-programmable clock divider producing a divided square wave and a single-cycle tick enable from one system clock. It is the parametrised successor to the fixed divider and serves the distance-sensor and LED-display paths: trigger pulse timing, echo sampling rate and digit multiplexing. The divisor can change on the fly, and a change takes effect only at a period boundary so ClockOut never glitches. Downstream logic stays on ClockIn and uses TickOut as a clock enable.

Parameters:
WIDTH  16  bit width of divisor and counter
DEFAULT_DIV  50000  divisor loaded at reset; must be in 2..2^WIDTH-1

Ports:
ClockIn  input  1  system clock; all logic on its rising edge
ResetN  input  1  asynchronous, active-low reset
Enable  input  1  count enable; low freezes all state
Restart  input  1  synchronous restart of the current period
DivIn  input  WIDTH  requested divisor
DivLoad  input  1  single-cycle strobe that captures DivIn
ClockOut  output  1  divided clock, registered
TickOut  output  1  one-cycle pulse per completed period, registered
DivBusy  output  1  high while a loaded divisor is pending
CountOut  output  WIDTH  current phase counter, registered

Behaviour:
- Interface: one clock, ClockIn. ResetN is asynchronous and active-low.
- Effective divisor: Deff = max(Active, 2). A divisor value of 0 or 1 is clamped to 2 when it is captured.
- Reset (ResetN=0, takes effect immediately, no clock needed):
  - Count=0, ClockOut=0, TickOut=0, DivBusy=0.
  - Active=DEFAULT_DIV, Pending=DEFAULT_DIV.
- Each rising edge with Enable=1 and Restart=0:
  - If Count==Deff-1: Count<=0 (wrap), TickOut<=1, and Active<=Pending if DivBusy=1; DivBusy<=0.
  - Otherwise: Count<=Count+1, TickOut<=0.
- ClockOut is registered together with Count and always equals (Count >= Deff - floor(Deff/2)).
  - Result: low for ceil(Deff/2) cycles, then high for floor(Deff/2) cycles; period is Deff cycles.
  - Odd Deff gives the extra cycle to the low phase.
- TickOut is high exactly for the single cycle in which Count==0 following a wrap. It is never asserted after reset or after Restart.
- Enable=0: Count, ClockOut and Active hold; TickOut<=0. DivLoad is still honoured while Enable=0.
- DivLoad=1:
  - Pending<=clamp(DivIn) and DivBusy<=1.
  - A later DivLoad before the wrap overwrites Pending; the last value wins.
- DivLoad in the same cycle as a wrap: the wrap uses clamp(DivIn) directly, so Active<=clamp(DivIn) and DivBusy<=0.
- Restart=1 (synchronous; takes priority over Enable and the wrap):
  - Count<=0, ClockOut<=0, TickOut<=0.
  - Active<=Pending (or clamp(DivIn) if DivLoad is also 1); DivBusy<=0.
- Loading a smaller divisor while Count >= new Deff is safe: the old Active governs until the wrap, so there is no skipped or runaway period.
- Latency: a divisor change is visible on the first period after the next wrap, or on the cycle after Restart.
- Asserting ResetN mid-period aborts the period with no TickOut and restores DEFAULT_DIV.
- CountOut = Count.

Test Plan:
1. Reset, then Enable=1 with DEFAULT_DIV overridden to 4 -> ClockOut low 2 / high 2 cycles; TickOut pulses every 4 cycles, first pulse 4 cycles after Enable rises.
2. DivLoad DivIn=5 at Count=1 of a Deff=4 period -> DivBusy=1 until the wrap; next period is 5 cycles (low 3, high 2); TickOut spacing goes 4 then 5.
3. DivIn=0 and DivIn=1 loaded -> behaves as Deff=2, ClockOut toggles every cycle, TickOut every 2 cycles.
4. Enable low for 7 cycles mid-period at Count=2 (Deff=6) -> Count, ClockOut and CountOut frozen, TickOut=0; period resumes and completes 4 cycles after re-enable.
5. DivLoad DivIn=3 coinciding with a wrap, and separately with Restart -> Active=3 immediately, DivBusy never seen high, next period 3 cycles.
6. ResetN pulsed low asynchronously mid-period while DivBusy=1 -> all outputs 0 immediately without a clock edge; Active=DEFAULT_DIV; the pending load is discarded.
